// File: rtl/uart_pkg.sv
// Shared state encoding, parity-mode constants and the parity helper for the UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_e;

    localparam logic PAR_MODE_EVEN = 1'b0;
    localparam logic PAR_MODE_ODD  = 1'b1;
    localparam int   MAX_DATA_BITS = 9;

    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input logic                     mode);
        return (^data) ^ (mode == PAR_MODE_ODD);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: tick marks the last clk cycle of every DIV-cycle bit slot.
module uart_baud_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_r;

    // Counter restarts from zero when a word is accepted so the start bit gets a full slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (cnt_r == LAST) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + ONE;
        end
    end

    assign tick = (cnt_r == LAST);

endmodule

// File: rtl/uart_tx_stream.sv
// Valid/ready fed UART transmitter with registered tx/s_ready/busy.
// Define UART_TX_PARITY_EN to insert a parity bit between data and stop bits.
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115_200,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int             DIV       = CLK_FREQ_HZ / BAUD;
    localparam int             BCW       = 4;
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);
    localparam logic [BCW-1:0] BCNT_ONE  = BCW'(1);

    if (DIV < 2) begin : g_div_check
        $error("uart_tx_stream: CLK_FREQ_HZ/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_data_check
        $error("uart_tx_stream: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
        $error("uart_tx_stream: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_par_check
        $error("uart_tx_stream: PARITY_ODD must be 0 or 1");
    end

    uart_tx_state_e       state_r, state_next_s;
    logic [DATA_BITS-1:0] shift_r, shift_next_s;
    logic [BCW-1:0]       bit_cnt_r, bit_cnt_next_s;
    logic                 tx_r, tx_next_s;
    logic                 ready_r, ready_next_s;
    logic                 busy_r, busy_next_s;
    logic                 tick_s;
    logic                 accept_s;
    logic                 last_data_s;
    logic                 last_stop_s;

    assign accept_s    = s_valid && ready_r && (state_r == IDLE);
    assign last_data_s = (bit_cnt_r == LAST_DATA);
    assign last_stop_s = (bit_cnt_r == LAST_STOP);

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept_s),
        .tick  (tick_s)
    );

`ifdef UART_TX_PARITY_EN
    logic parity_r;

    // Parity is fixed at acceptance so it never depends on the shifting data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_r <= 1'b0;
        end else if (accept_s) begin
            parity_r <= calc_parity(MAX_DATA_BITS'(s_data),
                                    (PARITY_ODD != 0) ? PAR_MODE_ODD : PAR_MODE_EVEN);
        end else begin
            parity_r <= parity_r;
        end
    end
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic: every non-idle state advances only on a bit tick
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_next_s = START;
                else          state_next_s = IDLE;
            end
            START: begin
                if (tick_s) state_next_s = DATA;
                else        state_next_s = START;
            end
            DATA: begin
                if (tick_s && last_data_s) begin
`ifdef UART_TX_PARITY_EN
                    state_next_s = PARITY;
`else
                    state_next_s = STOP;
`endif
                end else begin
                    state_next_s = DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick_s) state_next_s = STOP;
                else        state_next_s = PARITY;
            end
`endif
            STOP: begin
                if (tick_s && last_stop_s) state_next_s = IDLE;
                else                       state_next_s = STOP;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Shift register and data/stop bit counter next values
    always_comb begin
        shift_next_s   = shift_r;
        bit_cnt_next_s = bit_cnt_r;
        if (accept_s) begin
            shift_next_s   = s_data;
            bit_cnt_next_s = {BCW{1'b0}};
        end else if (tick_s && (state_r == DATA)) begin
            shift_next_s   = {1'b0, shift_r[DATA_BITS-1:1]};
            bit_cnt_next_s = last_data_s ? {BCW{1'b0}} : (bit_cnt_r + BCNT_ONE);
        end else if (tick_s && (state_r == STOP)) begin
            bit_cnt_next_s = last_stop_s ? {BCW{1'b0}} : (bit_cnt_r + BCNT_ONE);
        end else begin
            shift_next_s   = shift_r;
            bit_cnt_next_s = bit_cnt_r;
        end
    end

    // FSM output logic, decoded from the upcoming state so outputs can be registered
    always_comb begin
        tx_next_s    = 1'b1;
        ready_next_s = 1'b0;
        busy_next_s  = 1'b1;
        case (state_next_s)
            IDLE: begin
                tx_next_s    = 1'b1;
                ready_next_s = 1'b1;
                busy_next_s  = 1'b0;
            end
            START:  tx_next_s = 1'b0;
            DATA:   tx_next_s = shift_next_s[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_next_s = parity_r;
`endif
            STOP:   tx_next_s = 1'b1;
            default: begin
                tx_next_s    = 1'b1;
                ready_next_s = 1'b0;
                busy_next_s  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset parks the line at mark with s_ready low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r   <= {DATA_BITS{1'b0}};
            bit_cnt_r <= {BCW{1'b0}};
            tx_r      <= 1'b1;
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            shift_r   <= shift_next_s;
            bit_cnt_r <= bit_cnt_next_s;
            tx_r      <= tx_next_s;
            ready_r   <= ready_next_s;
            busy_r    <= busy_next_s;
        end
    end

    assign tx      = tx_r;
    assign s_ready = ready_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: table of frames checked by a scoreboard monitor, plus timing corner sequences.
module tb_uart_tx_stream;

    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB_A  = 1 + 8 + PAR + 1;
    localparam int NB_B  = 1 + 7 + PAR + 2;
    localparam int B_ODD = 1;

    typedef struct {
        logic [7:0] data;
        logic       par_even;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] a_data;
    logic       a_valid, a_ready, a_tx, a_busy;
    logic [6:0] b_data;
    logic       b_valid, b_ready, b_tx, b_busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] sb_q[$];
    bit          mon_act = 1'b0;
    int          mon_cyc = 0;
    logic        mon_ok = 1'b1;
    logic [15:0] mon_exp = 16'hFFFF;
    vec_t        vecs[10];

    always #5 clk = ~clk;

    uart_tx_stream #(
        .CLK_FREQ_HZ (50_000_000), .BAUD (5_000_000),
        .DATA_BITS (8), .STOP_BITS (1), .PARITY_ODD (0)
    ) dut_a (
        .clk (clk), .rst_n (rst_n), .s_data (a_data), .s_valid (a_valid),
        .s_ready (a_ready), .tx (a_tx), .busy (a_busy)
    );

    uart_tx_stream #(
        .CLK_FREQ_HZ (50_000_000), .BAUD (5_000_000),
        .DATA_BITS (7), .STOP_BITS (2), .PARITY_ODD (B_ODD)
    ) dut_b (
        .clk (clk), .rst_n (rst_n), .s_data (b_data), .s_valid (b_valid),
        .s_ready (b_ready), .tx (b_tx), .busy (b_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic logic even_par(input logic [8:0] d);
        int ones = 0;
        for (int i = 0; i < 9; i++) if (d[i] === 1'b1) ones++;
        return (ones % 2) == 1;
    endfunction

    // Line levels LSB first: start, data, optional parity, then mark for the stop bits.
    function automatic logic [15:0] frame_model(input logic [8:0] data, input int nd,
                                                input logic par_even, input int odd);
        logic [15:0] f = 16'hFFFF;
        f[0] = 1'b0;
        for (int i = 0; i < nd; i++) f[1 + i] = data[i];
        if (PAR == 1) f[1 + nd] = par_even ^ (odd != 0);
        return f;
    endfunction

    // Scoreboard monitor for dut_a: pops one expected frame per start bit and checks each bit slot.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_act = 1'b0;
                sb_q.delete();
            end else begin
                if (!mon_act && a_tx === 1'b0) begin
                    if (sb_q.size() == 0) begin
                        fail_now("a_unexpected_frame", "start bit seen, no frame queued");
                    end else begin
                        mon_exp = sb_q.pop_front();
                        mon_act = 1'b1;
                        mon_cyc = 0;
                        mon_ok  = 1'b1;
                    end
                end
                if (mon_act) begin
                    if (a_tx !== mon_exp[mon_cyc / DIV] || a_busy !== 1'b1 || a_ready !== 1'b0)
                        mon_ok = 1'b0;
                    if (mon_cyc % DIV == DIV - 1) begin
                        check($sformatf("a_bit%0d_exp%0b_ok", mon_cyc / DIV, mon_exp[mon_cyc / DIV]),
                              32'(mon_ok), 32'd1);
                        mon_ok = 1'b1;
                    end
                    mon_cyc++;
                    if (mon_cyc == NB_A * DIV) mon_act = 1'b0;
                end
            end
        end
    end

    task automatic wait_ready_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (a_ready === 1'b1 && !mon_act) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("a_ready_timeout", "s_ready not seen within 3000 cycles");
    endtask

    task automatic send_a(input logic [7:0] data, input logic par_even);
        bit ok;
        wait_ready_a(ok);
        a_data  = data;
        a_valid = 1'b1;
        sb_q.push_back(frame_model({1'b0, data}, 8, par_even, 0));
        @(posedge clk);
        #1;
        a_valid = 1'b0;
    endtask

    task automatic send_check_b(input logic [6:0] data);
        logic [15:0] f;
        logic        ok;
        bit          rdy = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (b_ready === 1'b1) begin
                rdy = 1'b1;
                break;
            end
        end
        if (!rdy) fail_now("b_ready_timeout", "s_ready not seen within 3000 cycles");
        f       = frame_model({2'b00, data}, 7, even_par({2'b00, data}), B_ODD);
        b_data  = data;
        b_valid = 1'b1;
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        ok = 1'b1;
        for (int c = 0; c < NB_B * DIV; c++) begin
            if (b_tx !== f[c / DIV] || b_busy !== 1'b1) ok = 1'b0;
            if (c % DIV == DIV - 1) begin
                check($sformatf("b_%0h_bit%0d_ok", data, c / DIV), 32'(ok), 32'd1);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        check("b_busy_after_frame", 32'(b_busy), 32'd0);
        check("b_ready_after_frame", 32'(b_ready), 32'd1);
        check("b_tx_after_frame", 32'(b_tx), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int n;
        int rdy;
        int gap;
        bit idle_ok;

        vecs[0] = '{8'h55, 1'b0};  vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'hA5, 1'b0};  vecs[3] = '{8'h3C, 1'b0};
        vecs[4] = '{8'h00, 1'b0};  vecs[5] = '{8'hFF, 1'b0};
        vecs[6] = '{8'h81, 1'b0};  vecs[7] = '{8'h01, 1'b1};
        vecs[8] = '{8'h80, 1'b1};  vecs[9] = '{8'hFE, 1'b1};

        rst_n = 1'b0;  a_valid = 1'b0;  b_valid = 1'b0;
        a_data = 8'h00;  b_data = 7'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(a_tx), 32'd1);
        check("rst_ready", 32'(a_ready), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_first_edge", 32'(a_ready), 32'd1);

        // 0x55 8N1: start bit one cycle after accept, busy for the whole frame
        wait_ready_a(ok);
        check("tx_idle_before_accept", 32'(a_tx), 32'd1);
        a_data  = 8'h55;
        a_valid = 1'b1;
        sb_q.push_back(frame_model({1'b0, 8'h55}, 8, 1'b0, 0));
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        check("start_latency_tx", 32'(a_tx), 32'd0);
        check("start_latency_ready", 32'(a_ready), 32'd0);
        n = 0;
        for (int i = 0; i < 500; i++) begin
            if (a_busy !== 1'b1) break;
            n++;
            @(posedge clk);
            #1;
        end
        check("busy_len", n, NB_A * DIV);

        for (int v = 0; v < 10; v++) send_a(vecs[v].data, vecs[v].par_even);

        // s_valid held high: second start exactly one frame plus one idle cycle later
        wait_ready_a(ok);
        a_data  = 8'hA5;
        a_valid = 1'b1;
        sb_q.push_back(frame_model({1'b0, 8'hA5}, 8, 1'b0, 0));
        @(posedge clk);
        #1;
        a_data = 8'h3C;
        sb_q.push_back(frame_model({1'b0, 8'h3C}, 8, 1'b0, 0));
        rdy = 0;
        gap = 0;
        for (int i = 1; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (a_ready === 1'b1) rdy++;
            if (rdy > 0 && a_tx === 1'b0) begin
                gap = i;
                break;
            end
        end
        a_valid = 1'b0;
        check("b2b_start_gap", gap, NB_A * DIV + 1);
        check("b2b_ready_cycles", rdy, 1);

        // Reset during data bit 3 of 0xF0 (that bit is 0, so the forced mark is visible)
        send_a(8'hF0, 1'b0);
        repeat (44) @(posedge clk);
        #2;
        check("tx_bit3_before_reset", 32'(a_tx), 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", 32'(a_tx), 32'd1);
        check("async_rst_busy", 32'(a_busy), 32'd0);
        check("async_rst_ready", 32'(a_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 32'(a_ready), 32'd1);
        idle_ok = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (a_tx !== 1'b1 || a_busy !== 1'b0) idle_ok = 1'b0;
        end
        check("no_resume_after_reset", 32'(idle_ok), 32'd1);
        send_a(8'h81, 1'b0);

        // s_data scrambled mid-frame with s_valid low must not disturb the frame
        send_a(8'hC3, 1'b0);
        repeat (NB_A * DIV) begin
            @(negedge clk);
            a_data = 8'($urandom);
        end
        wait_ready_a(ok);

        // 7 data bits, 2 stop bits
        send_check_b(7'h7F);
        send_check_b(7'h07);
        send_check_b(7'h2A);

        wait_ready_a(ok);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
